// File: rtl/addrgen_pkg.sv
// Shared constants, lane request type and address helper for the addrgen pipeline.
// Counter width is only used when ADDRGEN_COUNT_EN is defined.
package addrgen_pkg;
  localparam int COORD_W   = 11;
  localparam int ADDR_W    = 32;
  localparam int OFFS_W    = 24;
  localparam int PIX_SHIFT = 1;
  localparam int MUL_W     = 2 * COORD_W;
  localparam int SUM_W     = MUL_W + 1;
  localparam int NUM_LANES = 2;
  localparam int CNT_W     = 22;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [ADDR_W-1:0]  base;
  } coord_t;

  // 16 bpp: pixel index shifted to bytes, zero-extended, added modulo 2^32.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0]  base,
                                                 input logic [MUL_W-1:0]   mul,
                                                 input logic [COORD_W-1:0] x);
    logic [SUM_W-1:0]  sum;
    logic [OFFS_W-1:0] offs;
    sum  = SUM_W'(mul) + SUM_W'(x);
    offs = OFFS_W'(sum) << PIX_SHIFT;
    return base + ADDR_W'(offs);
  endfunction
endpackage

// File: rtl/addrgen_lane.sv
// One address lane: registered y*hres in stage 1, final base+offset add in stage 2.
module addrgen_lane
  import addrgen_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ce1_i,
  input  logic               ce2_i,
  input  logic [COORD_W-1:0] hres_i,
  input  coord_t             crd_i,
  output logic [ADDR_W-1:0]  addr_o
);
  logic [MUL_W-1:0]   mul_q, mul_d;
  logic [COORD_W-1:0] x_q;
  logic [ADDR_W-1:0]  base_q;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  always_comb begin
    mul_d  = MUL_W'(crd_i.y) * MUL_W'(hres_i);
    addr_d = pix_addr(base_q, mul_q, x_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_q  <= '0;
      x_q    <= '0;
      base_q <= '0;
      addr_q <= '0;
    end else begin
      if (ce1_i) begin
        mul_q  <= mul_d;
        x_q    <= crd_i.x;
        base_q <= crd_i.base;
      end
      if (ce2_i) addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
endmodule

// File: rtl/addrgen.sv
// Two-stage dst/src framebuffer address generator with ready/next handshakes.
// Optional accepted-output counter enabled by defining ADDRGEN_COUNT_EN.
module addrgen
  import addrgen_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] hres,
  input  logic [ADDR_W-1:0]  dst_base,
  input  logic [ADDR_W-1:0]  src_base,
  input  logic [COORD_W-1:0] td_x,
  input  logic [COORD_W-1:0] td_y,
  input  logic [COORD_W-1:0] ts_x,
  input  logic [COORD_W-1:0] ts_y,
  input  logic               bc_ready,
  output logic               bc_next,
  output logic [ADDR_W-1:0]  dst_addr,
  output logic [ADDR_W-1:0]  src_addr,
  output logic               ag_ready,
  input  logic               ag_next
`ifdef ADDRGEN_COUNT_EN
  ,
  input  logic               count_clr,
  output logic [CNT_W-1:0]   pixel_count
`endif
);
  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe_q, vld_pipe_d;
  logic            ce1, ce2;
  coord_t [NUM_LANES-1:0]             crd;
  logic   [NUM_LANES-1:0][ADDR_W-1:0] addr;

  // Stage 2 advances when empty or drained; stage 1 when empty or stage 2 advances.
  assign ce2 = ~vld_pipe_q[2] | ag_next;
  assign ce1 = ~vld_pipe_q[1] | ce2;
  // Pipeline is being emptied while rst is high, so offer acceptance.
  assign bc_next = ce1 | rst;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (ce1) vld_pipe_d[1] = bc_ready;
    if (ce2) vld_pipe_d[2] = vld_pipe_q[1];
  end

  always_ff @(posedge clk) begin
    if (rst) vld_pipe_q <= '0;
    else     vld_pipe_q <= vld_pipe_d;
  end

  assign crd[0] = '{x: td_x, y: td_y, base: dst_base};
  assign crd[1] = '{x: ts_x, y: ts_y, base: src_base};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    addrgen_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .ce1_i  (ce1),
      .ce2_i  (ce2),
      .hres_i (hres),
      .crd_i  (crd[l]),
      .addr_o (addr[l])
    );
  end

  assign dst_addr = addr[0];
  assign src_addr = addr[1];
  assign ag_ready = vld_pipe_q[2];

`ifdef ADDRGEN_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (count_clr)               cnt_d = '0;
    else if (ag_ready & ag_next) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign pixel_count = cnt_q;
`endif
endmodule

// File: doc/addrgen.md
ADDRGEN -- requirements
Module: addrgen

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; the polarity and synchronicity are fixed.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 hres  in  11  horizontal resolution in pixels (line pitch).
REQ-005 dst_base, src_base  in  32  byte base addresses of destination and source framebuffers.
REQ-006 td_x, td_y, ts_x, ts_y  in  11 each  checked destination and source coordinates from the boundary-check stage.
REQ-007 bc_ready  in  1  upstream holds a valid coordinate set.
REQ-008 bc_next  out  1  this block accepts the set this cycle.
REQ-009 dst_addr, src_addr  out  32  computed byte addresses.
REQ-010 ag_ready  out  1  address pair valid.
REQ-011 ag_next  in  1  downstream consumes the pair.
REQ-012 count_clr  in  1  clears pixel_count; present only with ADDRGEN_COUNT_EN.
REQ-013 pixel_count  out  22  accepted-output tally; present only with ADDRGEN_COUNT_EN.

Function
REQ-014 SHALL compute addr = base + (((y*hres) + x) << 1) for 16 bpp pixels; y*hres is 22 bits, the sum 23 bits and the shifted offset 24 bits, zero-extended to 32 bits; the 32-bit add wraps modulo 2^32.
REQ-015 SHALL form a two-stage pipeline: stage 1 registers y*hres, x and base per lane plus s1_valid; stage 2 registers the final sums into dst_addr/src_addr and ag_ready.
REQ-016 ce2 = ~ag_ready | ag_next; ce1 = ~s1_valid | ce2; bc_next = ce1 (combinational).
REQ-017 On ce1, stage 1 SHALL load the inputs and set s1_valid <= bc_ready; a transfer occurs only when bc_ready & bc_next.
REQ-018 On ce2, stage 2 SHALL load from stage 1 and set ag_ready <= s1_valid.
REQ-019 Latency: a set accepted at edge N SHALL appear with ag_ready high after edge N+1 when ag_next stays high; throughput is one pair per cycle.
REQ-020 hres and the bases SHALL be sampled with the data at stage 1; a later change SHALL affect only subsequently accepted sets.
REQ-021 Under backpressure (ag_ready & ~ag_next), stage 2 SHALL hold its contents; stage 1 SHALL fill if empty, and then bc_next SHALL go low; there SHALL be no loss and no duplication.
REQ-022 An empty stage 2 SHALL be refilled in the same cycle it empties (no bubble on ag_ready & ag_next with s1_valid).
REQ-023 Outputs SHALL be stable while ag_ready & ~ag_next.

Reset
REQ-024 On rst: s1_valid=0, ag_ready=0, dst_addr=0, src_addr=0, stage-1 data=0, pixel_count=0; rst during operation SHALL discard in-flight sets.
REQ-025 bc_next SHALL be 1 during and immediately after reset (pipeline empty).

Configuration
REQ-026 ADDRGEN_COUNT_EN defined: pixel_count SHALL increment by 1 on each ag_ready & ag_next, wrapping from 2^22-1 to 0; count_clr SHALL set it to 0, and count_clr wins over a simultaneous increment.
REQ-027 ADDRGEN_COUNT_EN undefined: count_clr, pixel_count and the counter logic SHALL be absent, with all other behaviour identical.

Structure
REQ-028 A shared package SHALL hold the constants COORD_W=11, ADDR_W=32, OFFS_W=24 and PIX_SHIFT=1.
REQ-029 Each lane (dst, src) SHALL be one instance of sub-module addrgen_lane: the registered multiply in stage 1 and the add in stage 2, with ce1/ce2 supplied by addrgen.

Verification
REQ-030 hres=640, dst_base=0x10000000, td=(3,2), ag_next=1 -> dst_addr=0x10000A06, ag_ready high 2 edges after acceptance.
REQ-031 src_base=0x20000000, ts=(639,479), hres=640 -> src_addr=0x20095FFE.
REQ-032 dst_base=0xFFFFFFFE, td=(1,0) -> dst_addr=0x00000000 (wrap).
REQ-033 Stream of 10 sets with ag_next low for 5 cycles mid-stream -> bc_next low after stage 1 fills; 10 outputs appear in order, none lost or duplicated.
REQ-034 rst asserted with both stages full -> next cycle ag_ready=0 and bc_next=1; no stale pair is emitted afterward.
REQ-035 ADDRGEN_COUNT_EN, 7 handshakes, then count_clr coinciding with an 8th handshake -> pixel_count 7, then 0.
